// File: rtl/c17_bist_pkg.sv
// Shared types and constants for the c17 self-test engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package c17_bist_pkg;

    localparam int LFSR_W   = 5;
    localparam int MISR_W   = 8;
    localparam int CNT_W    = 16;
    localparam int SETTLE_W = 4;

    // Feedback taps for x^5+x^3+1: bits 4 and 2 of the state register.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 5'b10100;
    localparam logic [MISR_W-1:0] MISR_POLY = 8'h1D;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_APPLY,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    // One Fibonacci step: shift left, feedback enters at bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/c17_misr8.sv
// 8-bit Galois MISR compacting one response word per enabled cycle.
// Latency: signature updates on the clock edge after i_en; o_sig_next is combinational.
// Backpressure: none; load has priority over enable.
module c17_misr8
    import c17_bist_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic              i_en,
    input  logic [MISR_W-1:0] i_seed,
    input  logic [MISR_W-1:0] i_data,
    output logic [MISR_W-1:0] o_sig,
    output logic [MISR_W-1:0] o_sig_next
);

    logic [MISR_W-1:0] r_sig;

    assign o_sig_next = ({r_sig[MISR_W-2:0], 1'b0} ^ (r_sig[MISR_W-1] ? MISR_POLY : '0)) ^ i_data;
    assign o_sig      = r_sig;

    // Signature register: seed on load, compact on enable, otherwise hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sig <= '0;
        end else if (i_load) begin
            r_sig <= i_seed;
        end else if (i_en) begin
            r_sig <= o_sig_next;
        end
    end

endmodule

// File: rtl/c17_bist_engine.sv
// BIST wrapper for c17: LFSR patterns out, MISR compaction of responses, golden compare.
// Latency: done rises 1 + NUM_PATTERNS*(SETTLE+1) cycles after start is sampled.
// Backpressure: none; start is ignored while busy, no queueing.
module c17_bist_engine
    import c17_bist_pkg::*;
#(
    parameter int                NUM_PATTERNS = 31,
    parameter int                SETTLE       = 1,
    parameter logic [LFSR_W-1:0] LFSR_SEED    = 5'h01,
    parameter logic [MISR_W-1:0] MISR_SEED    = 8'h00,
    parameter logic [MISR_W-1:0] GOLDEN_SIG   = 8'h00
) (
    input  logic              CLK,
    input  logic              RESET_B,
    input  logic              start,
    output logic [LFSR_W-1:0] pat_out,
    input  logic [1:0]        resp_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [MISR_W-1:0] signature,
    output logic [CNT_W-1:0]  pat_cnt
);

    localparam logic [CNT_W-1:0]    LAST_PAT    = CNT_W'(NUM_PATTERNS - 1);
    localparam logic [SETTLE_W-1:0] LAST_SETTLE = SETTLE_W'(SETTLE - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [LFSR_W-1:0]   r_lfsr;
    logic [CNT_W-1:0]    r_pat_cnt;
    logic [SETTLE_W-1:0] r_settle;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;
    logic                w_load;
    logic                w_capture;
    logic                w_settle_end;
    logic                w_last_pat;
    logic [MISR_W-1:0]   w_sig;
    logic [MISR_W-1:0]   w_misr_next;

    assign w_load       = (r_state == ST_LOAD);
    assign w_capture    = (r_state == ST_CAPTURE);
    assign w_settle_end = (r_settle == LAST_SETTLE);
    assign w_last_pat   = (r_pat_cnt == LAST_PAT);

    c17_misr8 u_misr (
        .i_clk      (CLK),
        .i_rst_n    (RESET_B),
        .i_load     (w_load),
        .i_en       (w_capture),
        .i_seed     (MISR_SEED),
        .i_data     ({6'b0, resp_in}),
        .o_sig      (w_sig),
        .o_sig_next (w_misr_next)
    );

    // FSM state register.
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: load, then alternate apply/capture until the last pattern.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (start) w_state_nxt = ST_LOAD;
            ST_LOAD:    w_state_nxt = ST_APPLY;
            ST_APPLY:   if (w_settle_end) w_state_nxt = ST_CAPTURE;
            ST_CAPTURE: w_state_nxt = w_last_pat ? ST_DONE : ST_APPLY;
            ST_DONE:    if (start) w_state_nxt = ST_LOAD;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: pattern generator, counters and registered status flags.
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            r_lfsr    <= '0;
            r_pat_cnt <= '0;
            r_settle  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
        end else begin
            // Status flags follow the state being entered so they line up with it.
            r_busy <= (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_APPLY) ||
                      (w_state_nxt == ST_CAPTURE);
            r_done <= (w_state_nxt == ST_DONE);
            case (r_state)
                ST_LOAD: begin
                    r_lfsr    <= LFSR_SEED;
                    r_pat_cnt <= '0;
                    r_settle  <= '0;
                    r_pass    <= 1'b0;
                end
                ST_APPLY: begin
                    r_settle <= w_settle_end ? '0 : r_settle + 1'b1;
                end
                ST_CAPTURE: begin
                    r_lfsr    <= lfsr_step(r_lfsr);
                    r_pat_cnt <= r_pat_cnt + 1'b1;
                    // Compare against the signature being written this edge, not the old one.
                    if (w_last_pat) r_pass <= (w_misr_next == GOLDEN_SIG);
                end
                default: ;
            endcase
        end
    end

    assign pat_out   = r_lfsr;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign signature = w_sig;
    assign pat_cnt   = r_pat_cnt;

endmodule

// File: tb/tb_c17_bist_engine.sv
module tb_c17_bist_engine;

    logic        CLK;
    logic        RESET_B;
    logic [5:0]  start_v;
    logic [5:0]  busy_v;
    logic [5:0]  done_v;
    logic [5:0]  pass_v;
    logic [4:0]  pat_v [6];
    logic [7:0]  sig_v [6];
    logic [15:0] cnt_v [6];

    int checks = 0;
    int errors = 0;

    logic [4:0] pats [8];
    int         hold [8];
    int         unstable;
    logic [4:0] p32;

    typedef struct {
        int          k;
        int          poke;
        int          cyc;
        logic [7:0]  sig;
        logic        pass;
        logic [15:0] cnt;
    } vec_t;
    vec_t tbl [8];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // k0: defaults; k1: 32 patterns; k2/k3: two patterns, resp 01, golden 03/00;
    // k4: MISR seed 80, one pattern, resp 10; k5: settle 3, four patterns.
    c17_bist_engine #(.NUM_PATTERNS(31)) u0 (.CLK(CLK), .RESET_B(RESET_B), .start(start_v[0]),
        .pat_out(pat_v[0]), .resp_in(2'b00), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
        .signature(sig_v[0]), .pat_cnt(cnt_v[0]));
    c17_bist_engine #(.NUM_PATTERNS(32)) u1 (.CLK(CLK), .RESET_B(RESET_B), .start(start_v[1]),
        .pat_out(pat_v[1]), .resp_in(2'b00), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
        .signature(sig_v[1]), .pat_cnt(cnt_v[1]));
    c17_bist_engine #(.NUM_PATTERNS(2), .GOLDEN_SIG(8'h03)) u2 (.CLK(CLK), .RESET_B(RESET_B),
        .start(start_v[2]), .pat_out(pat_v[2]), .resp_in(2'b01), .busy(busy_v[2]), .done(done_v[2]),
        .pass(pass_v[2]), .signature(sig_v[2]), .pat_cnt(cnt_v[2]));
    c17_bist_engine #(.NUM_PATTERNS(2), .GOLDEN_SIG(8'h00)) u3 (.CLK(CLK), .RESET_B(RESET_B),
        .start(start_v[3]), .pat_out(pat_v[3]), .resp_in(2'b01), .busy(busy_v[3]), .done(done_v[3]),
        .pass(pass_v[3]), .signature(sig_v[3]), .pat_cnt(cnt_v[3]));
    c17_bist_engine #(.NUM_PATTERNS(1), .MISR_SEED(8'h80)) u4 (.CLK(CLK), .RESET_B(RESET_B),
        .start(start_v[4]), .pat_out(pat_v[4]), .resp_in(2'b10), .busy(busy_v[4]), .done(done_v[4]),
        .pass(pass_v[4]), .signature(sig_v[4]), .pat_cnt(cnt_v[4]));
    c17_bist_engine #(.NUM_PATTERNS(4), .SETTLE(3)) u5 (.CLK(CLK), .RESET_B(RESET_B),
        .start(start_v[5]), .pat_out(pat_v[5]), .resp_in(2'b00), .busy(busy_v[5]), .done(done_v[5]),
        .pass(pass_v[5]), .signature(sig_v[5]), .pat_cnt(cnt_v[5]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Start instance k, optionally pulse start again poke cycles in, and count
    // edges from the start-sampling edge until done.
    task automatic run(input int k, input int poke, output int cycles);
        for (int j = 0; j < 8; j++) begin
            hold[j] = 0;
            pats[j] = '0;
        end
        unstable   = 0;
        p32        = 5'h1f;
        start_v[k] = 1'b1;
        tick();
        start_v[k] = 1'b0;
        chk("busy_after_start", busy_v[k], 1);
        chk("done_low_after_start", done_v[k], 0);
        cycles = 0;
        while (!done_v[k] && cycles < 300) begin
            tick();
            cycles++;
            start_v[k] = (cycles == poke);
            if (busy_v[k] && cnt_v[k] < 16'd8) begin
                if (hold[cnt_v[k]] == 0) pats[cnt_v[k]] = pat_v[k];
                else if (pats[cnt_v[k]] != pat_v[k]) unstable++;
                hold[cnt_v[k]]++;
            end
            if (busy_v[k] && cnt_v[k] == 16'd31) p32 = pat_v[k];
        end
        start_v[k] = 1'b0;
        if (!done_v[k]) begin
            errors++;
            $display("FAIL run_timeout inst=%0d actual=not_done required=done", k);
        end
    endtask

    initial begin
        int cyc;
        tbl[0] = '{k: 0, poke: 0,  cyc: 63, sig: 8'h00, pass: 1'b1, cnt: 16'd31};
        tbl[1] = '{k: 0, poke: 20, cyc: 63, sig: 8'h00, pass: 1'b1, cnt: 16'd31};
        tbl[2] = '{k: 1, poke: 0,  cyc: 65, sig: 8'h00, pass: 1'b1, cnt: 16'd32};
        tbl[3] = '{k: 2, poke: 0,  cyc: 5,  sig: 8'h03, pass: 1'b1, cnt: 16'd2};
        tbl[4] = '{k: 2, poke: 0,  cyc: 5,  sig: 8'h03, pass: 1'b1, cnt: 16'd2};
        tbl[5] = '{k: 3, poke: 0,  cyc: 5,  sig: 8'h03, pass: 1'b0, cnt: 16'd2};
        tbl[6] = '{k: 4, poke: 0,  cyc: 3,  sig: 8'h1F, pass: 1'b0, cnt: 16'd1};
        tbl[7] = '{k: 5, poke: 0,  cyc: 17, sig: 8'h00, pass: 1'b1, cnt: 16'd4};

        RESET_B = 1'b1;
        start_v = '0;
        #2 RESET_B = 1'b0;
        #1;
        chk("rst_busy", busy_v, 6'b0);
        chk("rst_done", done_v, 6'b0);
        chk("rst_pass", pass_v, 6'b0);
        chk("rst_pat", pat_v[0], 0);
        chk("rst_sig", sig_v[0], 0);
        chk("rst_cnt", cnt_v[0], 0);
        tick();
        tick();
        RESET_B = 1'b1;
        tick();
        chk("idle_busy", busy_v, 6'b0);

        for (int i = 0; i < 8; i++) begin
            run(tbl[i].k, tbl[i].poke, cyc);
            chk($sformatf("v%0d_cycles", i), cyc, tbl[i].cyc);
            chk($sformatf("v%0d_sig", i), sig_v[tbl[i].k], tbl[i].sig);
            chk($sformatf("v%0d_pass", i), pass_v[tbl[i].k], tbl[i].pass);
            chk($sformatf("v%0d_cnt", i), cnt_v[tbl[i].k], tbl[i].cnt);
            chk($sformatf("v%0d_busy_end", i), busy_v[tbl[i].k], 0);
            if (i == 0) begin
                chk("seq_p0", pats[0], 5'h01);
                chk("seq_p1", pats[1], 5'h02);
                chk("seq_p2", pats[2], 5'h04);
                chk("seq_p3", pats[3], 5'h09);
                chk("seq_p4", pats[4], 5'h12);
            end
            if (i == 2) chk("wrap_p32", p32, 5'h01);
            if (i == 7) begin
                chk("settle_hold_p1", hold[1], 4);
                chk("settle_stable", unstable, 0);
            end
        end

        // Done must hold one cycle after completion while start stays low.
        tick();
        chk("done_holds", done_v[5], 1);

        // Asynchronous reset in the middle of a run.
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        for (int j = 0; j < 10; j++) tick();
        #2 RESET_B = 1'b0;
        #1;
        chk("mid_rst_busy", busy_v[0], 0);
        chk("mid_rst_pat", pat_v[0], 0);
        chk("mid_rst_sig", sig_v[0], 0);
        chk("mid_rst_cnt", cnt_v[0], 0);
        chk("mid_rst_done_other", done_v[5], 0);
        tick();
        RESET_B = 1'b1;
        for (int j = 0; j < 3; j++) tick();
        chk("post_rst_idle_busy", busy_v[0], 0);
        chk("post_rst_idle_cnt", cnt_v[0], 0);
        run(0, 0, cyc);
        chk("post_rst_cycles", cyc, 63);
        chk("post_rst_sig", sig_v[0], 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
